// File: rtl/tb_drv.sv
// Stimulus source for the PE array input stream: emits num_vec LFSR-derived beats over valid/ready.
// Optional valid throttling via a per-phase issue mask is built when TB_DRV_THROTTLE_EN is defined.
module tb_drv #(
   parameter int LANES = 4,
   parameter int CNT_W = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [CNT_W-1:0]      num_vec,
   input  logic [31:0]           seed,
   input  logic [7:0]            throttle_mask,
   output logic                  ivalid,
   input  logic                  iready,
   output logic [LANES*32-1:0]   idata,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_W-1:0]      sent_count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [31:0] LFSR_MASK = 32'h80200003;
   localparam logic [31:0] LANE_STEP = 32'h9E3779B9;

   logic [1:0]       state;
   logic [CNT_W-1:0] remaining;
   logic [31:0]      lfsr;
   logic [31:0]      lfsr_next;
   logic             xfer;
   logic             issue_first;
   logic             issue_next;

   assign xfer      = ivalid & iready;
   assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : '0);
   assign busy      = (state == S_RUN);
   assign done      = (state == S_DONE);

`ifdef TB_DRV_THROTTLE_EN
   logic [2:0] phase;
   logic [7:0] mask_eff;

   assign mask_eff    = (throttle_mask == '0) ? 8'hFF : throttle_mask;
   // ivalid is registered, so the issue decision looks one phase ahead
   assign issue_first = mask_eff[0];
   assign issue_next  = mask_eff[phase + 3'd1];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         phase <= '0;
      end else if (state == S_IDLE) begin
         phase <= '0;
      end else if (state == S_RUN) begin
         phase <= phase + 3'd1;
      end
   end
`else
   logic unused_throttle;

   assign unused_throttle = ^throttle_mask;
   assign issue_first     = 1'b1;
   assign issue_next      = 1'b1;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         ivalid     <= 1'b0;
         remaining  <= '0;
         lfsr       <= 32'd1;
         sent_count <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  sent_count <= '0;
                  if (num_vec != '0) begin
                     state     <= S_RUN;
                     remaining <= num_vec;
                     lfsr      <= (seed == '0) ? 32'd1 : seed;
                     ivalid    <= issue_first;
                  end else begin
                     state <= S_DONE;
                  end
               end
            end
            S_RUN: begin
               if (xfer) begin
                  if (sent_count != '1)
                     sent_count <= sent_count + CNT_W'(1);
                  remaining <= remaining - CNT_W'(1);
                  lfsr      <= lfsr_next;
                  if (remaining == CNT_W'(1)) begin
                     state  <= S_DONE;
                     ivalid <= 1'b0;
                  end else begin
                     ivalid <= issue_next;
                  end
               end else if (!ivalid) begin
                  ivalid <= issue_next;
               end
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // payload is forced to zero whenever no beat is presented
   always_comb begin
      idata = '0;
      if (ivalid) begin
         for (int unsigned k = 0; k < LANES; k++)
            idata[32*k +: 32] = lfsr ^ (LANE_STEP * 32'(k));
      end
   end

endmodule
